miriscv_data_mem: RTL and testbench

MIRISCV_DATA_MEM -- requirements
Module: miriscv_data_mem

---
 rtl/miriscv_data_mem.sv | 154 +++++++++++++++
 tb/tb_miriscv_data_mem.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_data_mem.sv
// rtl/miriscv_data_mem.sv - LSU data memory with fixed wait states and byte-lane writes
module miriscv_data_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ready_o,
    output logic        data_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;

    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          range_err;
    logic          be_err;
    logic          acc_err;
    logic [31:0]   merged;
    logic          addr_lsb_unused;

    // The byte lane travels on data_be_i, so the two address LSBs carry nothing.
    assign addr_lsb_unused = ^data_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arstn_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !arstn_i) begin
            we_q    <= data_we_i;
            be_q    <= data_be_i;
            addr_q  <= data_addr_i[31:2];
            wdata_q <= data_wdata_i;
        end
    end

    assign idx       = addr_q[AW-1:0];
    assign range_err = |addr_q[29:AW];
    assign acc_err   = range_err | be_err;

    // Only single bytes, aligned halves and the full word are legal lane patterns.
    always_comb begin
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_err = 1'b0;
            default:                   be_err = 1'b1;
        endcase
    end

    always_comb begin
        merged = mem_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i && state_q == RESP && we_q && !acc_err) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arstn_i) begin
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (state_q == RESP) begin
                ready_q <= 1'b1;
                if (acc_err) begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'd0;
                end else begin
                    rdata_q <= we_q ? merged : mem_q[idx];
                end
            end
        end
    end

    assign data_rdata_o = rdata_q;
    assign data_ready_o = ready_q;
    assign data_err_o   = err_q;

endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb/tb_miriscv_data_mem.sv - self-checking bench for miriscv_data_mem
module tb_miriscv_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_req, a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ready, a_err;

    logic        b_req, b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ready, b_err;

    logic        c_req, c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_ready, c_err;

    miriscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_a (
        .clk_i(clk), .arstn_i(rst), .data_req_i(a_req), .data_we_i(a_we),
        .data_be_i(a_be), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
        .data_rdata_o(a_rdata), .data_ready_o(a_ready), .data_err_o(a_err)
    );

    miriscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_b (
        .clk_i(clk), .arstn_i(rst), .data_req_i(b_req), .data_we_i(b_we),
        .data_be_i(b_be), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
        .data_rdata_o(b_rdata), .data_ready_o(b_ready), .data_err_o(b_err)
    );

    miriscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_c (
        .clk_i(clk), .arstn_i(rst), .data_req_i(c_req), .data_we_i(c_we),
        .data_be_i(c_be), .data_addr_i(c_addr), .data_wdata_i(c_wdata),
        .data_rdata_o(c_rdata), .data_ready_o(c_ready), .data_err_o(c_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=1 instance; lat counts edges from accept to ready.
    task automatic acc_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
        @(posedge clk);
        #1;
        a_req = 1'b0; a_we = $urandom_range(0, 1); a_be = 4'($urandom);
        a_addr = $urandom; a_wdata = $urandom;
        lat = -1; rdata = 32'd0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_ready) begin
                lat = k; rdata = a_rdata; err = a_err;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [17];

    logic [31:0] m_data  [16];
    logic [3:0]  m_known [16];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [63:0] pat, exp_pat;
        int          nerr;

        vt[0]  = '{1'b1, 4'b1111, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[1]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 4'b0100, 32'h10,   32'h55555555, 32'hDE55BEEF, 1'b0};
        vt[3]  = '{1'b0, 4'b0001, 32'h10,   32'h0,        32'hDE55BEEF, 1'b0};
        vt[4]  = '{1'b0, 4'b1111, 32'h1000, 32'h0,        32'h0,        1'b1};
        vt[5]  = '{1'b1, 4'b0110, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
        vt[6]  = '{1'b0, 4'b1111, 32'h12,   32'h0,        32'hDE55BEEF, 1'b0};
        vt[7]  = '{1'b1, 4'b1111, 32'h20,   32'h11111111, 32'h11111111, 1'b0};
        vt[8]  = '{1'b1, 4'b1111, 32'hFFC,  32'h12345678, 32'h12345678, 1'b0};
        vt[9]  = '{1'b0, 4'b1111, 32'hFFC,  32'h0,        32'h12345678, 1'b0};
        vt[10] = '{1'b1, 4'b0000, 32'h20,   32'hAAAAAAAA, 32'h0,        1'b1};
        vt[11] = '{1'b1, 4'b1000, 32'h23,   32'hAB000000, 32'hAB111111, 1'b0};
        vt[12] = '{1'b1, 4'b0011, 32'h20,   32'h9999CDEF, 32'hAB11CDEF, 1'b0};
        vt[13] = '{1'b1, 4'b1100, 32'h20,   32'h77770000, 32'h7777CDEF, 1'b0};
        vt[14] = '{1'b0, 4'b1111, 32'h20,   32'h0,        32'h7777CDEF, 1'b0};
        vt[15] = '{1'b1, 4'b1110, 32'h20,   32'h0,        32'h0,        1'b1};
        vt[16] = '{1'b0, 4'b0010, 32'h21,   32'h0,        32'h7777CDEF, 1'b0};

        rst = 1'b1;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        c_req = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(a_ready), 64'd0);
        chk("reset_err",   64'(a_err),   64'd0);
        chk("reset_rdata", 64'(a_rdata), 64'd0);

        // WAIT_CYCLES=0: accept on the very first edge out of reset
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_be = 4'b1111; c_addr = 32'h40; c_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1 c_req = 1'b0;
        lat = -1; rd = 32'd0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (c_ready && lat < 0) begin
                lat = k; rd = c_rdata;
            end
        end
        chk("w0_first_lat",   64'(lat), 64'd1);
        chk("w0_first_rdata", 64'(rd),  64'h0BADF00D);

        c_req = 1'b1; c_we = 1'b0; c_be = 4'b1111; c_addr = 32'h40;
        pat = '0; exp_pat = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            pat[k-1] = c_ready;
            exp_pat[k-1] = (k % 2 == 0);
            if (c_ready) chk("w0_b2b_rdata", 64'(c_rdata), 64'h0BADF00D);
        end
        c_req = 1'b0;
        chk("w0_b2b_pattern", pat, exp_pat);

        // WAIT_CYCLES=3: request held high, one accept every 5 edges
        b_req = 1'b1; b_we = 1'b0; b_be = 4'b1111; b_addr = 32'h0;
        pat = '0; exp_pat = '0; nerr = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            pat[k-1] = b_ready;
            exp_pat[k-1] = (k % 5 == 0);
            if (b_err) nerr++;
        end
        b_req = 1'b0;
        chk("busy_pattern", pat, exp_pat);
        chk("busy_err",     64'(nerr), 64'd0);

        for (int i = 0; i < 17; i++) begin
            acc_a(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_lat", i),   64'(lat), 64'd2);
            chk($sformatf("vec%0d_rdata", i), 64'(rd),  64'(vt[i].exp_rdata));
            chk($sformatf("vec%0d_err", i),   64'(er),  64'(vt[i].exp_err));
        end

        // Randomised accesses against a word/lane model of words 0x200..0x23C
        for (int i = 0; i < 16; i++) begin
            m_data[i] = 32'd0; m_known[i] = 4'd0;
        end
        for (int n = 0; n < 80; n++) begin
            logic        we;
            logic [3:0]  be;
            logic [31:0] addr, wd, exp, mask;
            logic        exp_err;
            int          w;
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            w  = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h1000;
            else addr = 32'h200 + 32'(w * 4) + 32'($urandom_range(0, 3));
            exp_err = ((addr >> 2) >= 32'd1024) ||
                      !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
            exp = 32'd0; mask = 32'hFFFFFFFF;
            if (!exp_err) begin
                if (we) begin
                    for (int l = 0; l < 4; l++)
                        if (be[l]) m_data[w][8*l +: 8] = wd[8*l +: 8];
                    m_known[w] = m_known[w] | be;
                end
                exp = m_data[w];
                for (int l = 0; l < 4; l++)
                    mask[8*l +: 8] = m_known[w][l] ? 8'hFF : 8'h00;
            end
            acc_a(we, be, addr, wd, rd, er, lat);
            chk("rand_lat",   64'(lat),       64'd2);
            chk("rand_err",   64'(er),        64'(exp_err));
            chk("rand_rdata", 64'(rd & mask), 64'(exp & mask));
        end

        // Reset during WAIT aborts a pending write
        acc_a(1'b1, 4'b1111, 32'h20, 32'h11111111, rd, er, lat);
        chk("rst_pre_rdata", 64'(rd), 64'h11111111);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_be = 4'b1111; a_addr = 32'h20; a_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ready", 64'(a_ready), 64'd0);
        chk("rst_mid_err",   64'(a_err),   64'd0);
        chk("rst_mid_rdata", 64'(a_rdata), 64'd0);
        rst = 1'b0;
        nerr = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_ready) nerr++;
        end
        chk("rst_mid_no_ready", 64'(nerr), 64'd0);
        acc_a(1'b0, 4'b1111, 32'h20, 32'h0, rd, er, lat);
        chk("rst_mid_read_lat",   64'(lat), 64'd2);
        chk("rst_mid_read_rdata", 64'(rd),  64'h11111111);

        // A request on the same edge as reset is dropped
        @(negedge clk);
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_be = 4'b1111; a_addr = 32'h20; a_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; a_req = 1'b0;
        nerr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_ready) nerr++;
        end
        chk("rst_prio_no_ready", 64'(nerr), 64'd0);
        acc_a(1'b0, 4'b1111, 32'h20, 32'h0, rd, er, lat);
        chk("rst_prio_rdata", 64'(rd), 64'h11111111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
